// File: rtl/exmem_skid_buffer_if.sv
// EX -> MEM handshake bundle for the EX/MEM skid buffer.
// slave: the buffer's view; master: the EX/MEM-stage environment driving it.
interface exmem_skid_buffer_if #(
    parameter int DW = 64,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic [DW-1:0] store_data;
    logic [RW-1:0] rd;
    logic [4:0]    ctrl;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic [DW-1:0] out_store_data;
    logic [RW-1:0] out_rd;
    logic [4:0]    out_ctrl;
    logic          pc_src;

    modport slave (
        input  in_valid, alu_result, alu_zero, store_data, rd, ctrl, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_store_data,
               out_rd, out_ctrl, pc_src
    );

    modport master (
        output in_valid, alu_result, alu_zero, store_data, rd, ctrl, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_store_data,
               out_rd, out_ctrl, pc_src
    );
endinterface

// File: rtl/exmem_skid_buffer.sv
// EX/MEM 2-entry skid buffer with registered in_ready and branch decision pc_src.
// Optional stall counter enabled by defining EXMEM_STALL_CNT_EN.
//
// state | meaning
// EMPTY | no entries, out_valid=0
// ONE   | main entry valid, skid empty
// FULL  | main and skid valid, in_ready=0
module exmem_skid_buffer #(
    parameter int DW = 64,
    parameter int RW = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    exmem_skid_buffer_if.slave  bus,
    output logic [31:0]         stall_cnt
);
    localparam int PW = 2*DW + RW + 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          in_ready_q;
    logic [PW-1:0] main_q, skid_q, in_pkt;
    logic          load_main_in, load_main_skid, load_skid_in;
    logic          out_valid, accept, consume;

    assign in_pkt    = {bus.alu_result, bus.alu_zero, bus.store_data, bus.rd, bus.ctrl};
    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign consume   = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d      = FULL;
                        load_skid_in = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is a flop so it never sees out_ready combinationally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_pkt;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid_in)
                skid_q <= in_pkt;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign {bus.out_result, bus.out_zero, bus.out_store_data, bus.out_rd, bus.out_ctrl} = main_q;
    assign bus.pc_src    = out_valid & bus.out_ctrl[0] & bus.out_zero;

`ifdef EXMEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_q <= '0;
        else if (out_valid && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_exmem_skid_buffer.sv
// Bench for exmem_skid_buffer: directed vector table, corner sequences, random vs queue model.
module tb_exmem_skid_buffer;
    localparam int DW = 64;
    localparam int RW = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    exmem_skid_buffer_if #(.DW(DW), .RW(RW)) bus ();

    exmem_skid_buffer #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
    } pkt_t;

    typedef struct {
        logic        iv, ordy, fl, zero;
        logic [4:0]  ctrl;
        logic [63:0] res;
        logic        e_ov, e_ir, e_pc, chk_res;
        logic [63:0] e_res;
    } vec_t;

    pkt_t model_q[$];
    int   stall_m;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [63:0] res, input logic zero, input logic [4:0] ctrl);
        bus.in_valid   = iv;
        bus.out_ready  = ordy;
        flush          = fl;
        bus.alu_result = res;
        bus.alu_zero   = zero;
        bus.store_data = ~res;
        bus.rd         = res[4:0];
        bus.ctrl       = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 5'h0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [63:0] res, input logic zero, input logic [4:0] ctrl,
                                input logic e_ov, input logic e_ir, input logic e_pc,
                                input logic chk_res, input logic [63:0] e_res);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.res = res; v.zero = zero; v.ctrl = ctrl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.chk_res = chk_res; v.e_res = e_res;
        return v;
    endfunction

    vec_t tbl[17];
    logic [31:0] exp_stall;

    initial begin
        // streaming
        tbl[0]  = mk(1,1,0, 64'h1, 0, 5'h0,  1,1,0, 1, 64'h1);
        tbl[1]  = mk(1,1,0, 64'h2, 0, 5'h0,  1,1,0, 1, 64'h2);
        tbl[2]  = mk(1,1,0, 64'h3, 0, 5'h0,  1,1,0, 1, 64'h3);
        tbl[3]  = mk(0,1,0, 64'h0, 0, 5'h0,  0,1,0, 0, 64'h0);
        // backpressure: A, B accepted, C held off until space frees
        tbl[4]  = mk(1,0,0, 64'hA, 0, 5'h0,  1,1,0, 1, 64'hA);
        tbl[5]  = mk(1,0,0, 64'hB, 0, 5'h0,  1,0,0, 1, 64'hA);
        tbl[6]  = mk(1,0,0, 64'hC, 0, 5'h0,  1,0,0, 1, 64'hA);
        tbl[7]  = mk(1,1,0, 64'hC, 0, 5'h0,  1,1,0, 1, 64'hB);
        tbl[8]  = mk(1,1,0, 64'hC, 0, 5'h0,  1,1,0, 1, 64'hC);
        tbl[9]  = mk(0,1,0, 64'h0, 0, 5'h0,  0,1,0, 0, 64'h0);
        // branch decision
        tbl[10] = mk(1,0,0, 64'h10, 1, 5'h01, 1,1,1, 1, 64'h10);
        tbl[11] = mk(1,1,0, 64'h11, 0, 5'h01, 1,1,0, 1, 64'h11);
        tbl[12] = mk(0,1,0, 64'h0, 0, 5'h0,  0,1,0, 0, 64'h0);
        // flush while FULL drops D
        tbl[13] = mk(1,0,0, 64'h20, 0, 5'h0, 1,1,0, 1, 64'h20);
        tbl[14] = mk(1,0,0, 64'h21, 0, 5'h0, 1,0,0, 1, 64'h20);
        tbl[15] = mk(1,0,1, 64'hD, 0, 5'h0,  0,1,0, 0, 64'h0);
        tbl[16] = mk(0,1,0, 64'h0, 0, 5'h0,  0,1,0, 0, 64'h0);

        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 5'h0);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i[0], ~i[0], 1'b0, 64'hF0 + 64'(i), 1'b1, 5'h1F);
            tick();
            chk("reset_ctl", {253'h0, bus.out_valid, bus.in_ready, bus.pc_src}, {253'h0, 3'b010});
            chk("reset_data", {192'h0, bus.out_result}, 256'h0);
            chk("reset_stall", {224'h0, stall_cnt}, 256'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 5'h0);
        reset_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].res, tbl[i].zero, tbl[i].ctrl);
            tick();
            chk($sformatf("vec%0d_ctl", i), {253'h0, bus.out_valid, bus.in_ready, bus.pc_src},
                {253'h0, tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_pc});
            if (tbl[i].chk_res)
                chk($sformatf("vec%0d_res", i), {192'h0, bus.out_result}, {192'h0, tbl[i].e_res});
        end

        // stall counter: one packet held for 7 cycles
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 64'h55, 1'b0, 5'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 5'h0);
        repeat (7) tick();
`ifdef EXMEM_STALL_CNT_EN
        exp_stall = 32'd7;
`else
        exp_stall = 32'd0;
`endif
        chk("stall_7", {224'h0, stall_cnt}, {224'h0, exp_stall});
        chk("stall_hold_data", {192'h0, bus.out_result}, {192'h0, 64'h55});
        drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 5'h0);
        tick();
        chk("stall_after_consume", {223'h0, bus.out_valid, stall_cnt}, {223'h0, 1'b0, exp_stall});

        // async reset mid-operation while FULL, no clock edge
        drive(1'b1, 1'b0, 1'b0, 64'h77, 1'b1, 5'h01);
        tick();
        drive(1'b1, 1'b0, 1'b0, 64'h78, 1'b1, 5'h01);
        tick();
        chk("pre_async_full", {254'h0, bus.out_valid, bus.in_ready}, {254'h0, 2'b10});
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_ctl", {253'h0, bus.out_valid, bus.in_ready, bus.pc_src}, {253'h0, 3'b010});
        chk("async_rst_data", {192'h0, bus.out_result}, 256'h0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 5'h0);
        tick();
        reset_n = 1'b1;

        // random traffic against queue model
        do_reset();
        model_q.delete();
        stall_m = 0;
        for (int c = 0; c < 500; c++) begin
            logic        iv, ordy, fl, acc, con;
            logic [63:0] res;
            logic [4:0]  ctl;
            logic        zr;
            pkt_t        p, h;
            logic [255:0] e, a;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 24) == 0);
            res  = {$urandom, $urandom};
            zr   = $urandom_range(0, 1);
            ctl  = 5'($urandom_range(0, 31));
            drive(iv, ordy, fl, res, zr, ctl);
            p.res = res; p.zero = zr; p.sd = ~res; p.rd = res[4:0]; p.ctrl = ctl;
            acc = iv && (model_q.size() < 2);
            con = (model_q.size() > 0) && ordy;
            if (model_q.size() > 0 && !ordy) stall_m++;
            if (fl) model_q.delete();
            else begin
                if (con) void'(model_q.pop_front());
                if (acc) model_q.push_back(p);
            end
            tick();
            e = '0;
            e[141] = (model_q.size() > 0);
            e[140] = (model_q.size() < 2);
            if (model_q.size() > 0) begin
                h = model_q[0];
                e[139] = h.ctrl[0] & h.zero;
                e[138:0] = {h.res, h.zero, h.sd, h.rd, h.ctrl};
            end
            a = '0;
            a[141] = bus.out_valid;
            a[140] = bus.in_ready;
            a[139] = bus.pc_src;
            if (bus.out_valid)
                a[138:0] = {bus.out_result, bus.out_zero, bus.out_store_data, bus.out_rd, bus.out_ctrl};
            chk($sformatf("rand%0d", c), a, e);
        end
`ifdef EXMEM_STALL_CNT_EN
        exp_stall = 32'(stall_m);
`else
        exp_stall = 32'd0;
`endif
        chk("rand_stall_cnt", {224'h0, stall_cnt}, {224'h0, exp_stall});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
